// File: rtl/rx_display_buffer_pkg.sv
// Shared constants and types for the received-byte display buffer.
package rx_display_buffer_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned NIB_W         = 4;

  // Pointer width for a given power-of-two history depth (at least 1 bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned PTR_W_DEFAULT = ptr_width(DEPTH_DEFAULT);

  // Everything the display controller sees, registered as one word.
  typedef struct packed {
    logic [NIB_W-1:0] d_hi;
    logic [NIB_W-1:0] d_lo;
    logic [NIB_W-1:0] sel_hi;
    logic [NIB_W-1:0] sel_lo;
  } disp_t;

endpackage

// File: rtl/rx_display_buffer_rise.sv
// Rising-edge detector for a debounced button level.
// A level already high when reset releases is ignored until it has been seen low.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  // Pulse on a 0->1 transition once the detector has observed the input low.
  always_comb begin
    prev_d  = level;
    armed_d = armed_q | ~level;
    pulse   = level & ~prev_q & armed_q;
  end

  // Previous-level and arming history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/rx_display_buffer.sv
// Keeps the last DEPTH received bytes and lets the buttons browse through them.
// Outputs are registered from next-state values, so an input sampled on an edge
// is visible on the outputs right after that same edge.
module rx_display_buffer
  import rx_display_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk_50Mhz,
  input  logic             reset,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  input  logic             btn_up,
  input  logic             btn_dn,
  output logic [NIB_W-1:0] d_hi,
  output logic [NIB_W-1:0] d_lo,
  output logic [NIB_W-1:0] bytesel_hi,
  output logic [NIB_W-1:0] bytesel_lo
);

  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam logic [3:0]  DEPTH4 = 4'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       offset_q, offset_d;
  disp_t            disp_q, disp_d;

  logic             up_evt, dn_evt;
  logic [3:0]       lim;
  logic [PTR_W-1:0] rd_idx;
  logic [7:0]       view;

  rise_edge_detect u_up (
    .clk   (clk_50Mhz),
    .reset (reset),
    .level (btn_up),
    .pulse (up_evt)
  );

  rise_edge_detect u_dn (
    .clk   (clk_50Mhz),
    .reset (reset),
    .level (btn_dn),
    .pulse (dn_evt)
  );

  // Next pointer/count/offset: write adjustment first, then buttons, then clamp.
  // The viewed byte bypasses the memory when the slot being written is on view.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    offset_d = offset_q;
    if (rx_rdy) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (count_q < DEPTH4) count_d = count_q + 4'd1;
      if (offset_q != 4'd0 && offset_q < DEPTH4 - 4'd1) offset_d = offset_q + 4'd1;
    end
    lim = (count_d == 4'd0) ? 4'd0 : count_d - 4'd1;
    if (up_evt && !dn_evt && offset_d < lim)
      offset_d = offset_d + 4'd1;
    else if (dn_evt && !up_evt && offset_d != 4'd0)
      offset_d = offset_d - 4'd1;
    if (offset_d > lim) offset_d = lim;

    rd_idx = wr_ptr_d - PTR_W'(1) - offset_d[PTR_W-1:0];
    if (count_d == 4'd0)
      view = 8'h00;
    else if (rx_rdy && offset_d == 4'd0)
      view = rx_data;
    else
      view = mem_q[rd_idx];

    disp_d.d_hi   = view[7:4];
    disp_d.d_lo   = view[3:0];
    disp_d.sel_hi = count_d;
    disp_d.sel_lo = offset_d;
  end

  // Control state and registered display outputs.
  always_ff @(posedge clk_50Mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      offset_q <= '0;
      disp_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      offset_q <= offset_d;
      disp_q   <= disp_d;
    end
  end

  // History storage; not reset because a zero count masks stale contents.
  always_ff @(posedge clk_50Mhz) begin
    if (rx_rdy && !reset) mem_q[wr_ptr_q] <= rx_data;
  end

  assign d_hi       = disp_q.d_hi;
  assign d_lo       = disp_q.d_lo;
  assign bytesel_hi = disp_q.sel_hi;
  assign bytesel_lo = disp_q.sel_lo;

endmodule

// File: tb/tb_rx_display_buffer.sv
// Directed self-checking bench for rx_display_buffer (DEPTH = 8).
module tb_rx_display_buffer;

  logic       clk_50Mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       rx_rdy    = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       btn_up    = 1'b0;
  logic       btn_dn    = 1'b0;
  logic [3:0] d_hi, d_lo, bytesel_hi, bytesel_lo;

  int unsigned errors = 0;
  int unsigned checks = 0;

  rx_display_buffer #(.DEPTH(8)) dut (
    .clk_50Mhz  (clk_50Mhz),
    .reset      (reset),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .d_hi       (d_hi),
    .d_lo       (d_lo),
    .bytesel_hi (bytesel_hi),
    .bytesel_lo (bytesel_lo)
  );

  always #5 clk_50Mhz = ~clk_50Mhz;

  task automatic step();
    @(posedge clk_50Mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] b,
                       input logic [3:0] cnt, input logic [3:0] off);
    logic [15:0] obs, exp;
    obs = {d_hi, d_lo, bytesel_hi, bytesel_lo};
    exp = {b, cnt, off};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    step();
    rx_rdy  = 1'b0;
  endtask

  task automatic press_up();
    btn_up = 1'b1; step(); btn_up = 1'b0; step();
  endtask

  task automatic press_dn();
    btn_dn = 1'b1; step(); btn_dn = 1'b0; step();
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0; step();
  endtask

  initial begin
    // Reset state
    step(); step();
    check("reset_held", 8'h00, 4'd0, 4'd0);
    reset = 1'b0; step();
    check("reset_released_empty", 8'h00, 4'd0, 4'd0);

    // Single write
    wr(8'hA5);
    check("first_write", 8'hA5, 4'd1, 4'd0);

    // Fill and wrap, then browse to the oldest
    do_reset();
    for (int i = 1; i <= 8; i++) wr(8'(8'h11 * i));
    check("full_newest", 8'h88, 4'd8, 4'd0);
    wr(8'h99);
    check("overwrite_newest", 8'h99, 4'd8, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      press_up();
      check("browse_up", 8'(8'h99 - 8'h11 * k), 4'd8, 4'(k));
    end
    press_up();
    check("up_at_oldest", 8'h22, 4'd8, 4'd7);

    // Full buffer, viewing the oldest, new write keeps offset clamped
    wr(8'hEE);
    check("write_full_clamp", 8'h33, 4'd8, 4'd7);

    // Asynchronous reset between edges, button held through reset
    btn_up = 1'b1;
    reset  = 1'b1;
    #2;
    check("async_reset", 8'h00, 4'd0, 4'd0);
    step();
    reset = 1'b0;
    step();
    wr(8'h10); wr(8'h20); wr(8'h30);
    check("held_btn_no_event", 8'h30, 4'd3, 4'd0);
    btn_up = 1'b0; step();
    press_up();
    check("btn_after_release", 8'h20, 4'd3, 4'd1);

    // Browse while writing keeps the same byte in view
    do_reset();
    wr(8'h10); wr(8'h20); wr(8'h30);
    press_up(); press_up();
    check("view_oldest_of_3", 8'h10, 4'd3, 4'd2);
    wr(8'h40);
    check("write_keeps_view", 8'h10, 4'd4, 4'd3);
    press_dn();
    check("down_1", 8'h20, 4'd4, 4'd2);
    press_dn();
    check("down_2", 8'h30, 4'd4, 4'd1);
    press_dn();
    check("down_3", 8'h40, 4'd4, 4'd0);
    press_dn();
    check("down_at_newest", 8'h40, 4'd4, 4'd0);

    // Held button gives one event; simultaneous edges cancel
    btn_up = 1'b1;
    repeat (100) step();
    check("held_100", 8'h30, 4'd4, 4'd1);
    btn_up = 1'b0; step();
    btn_up = 1'b1; btn_dn = 1'b1; step();
    check("both_edges", 8'h30, 4'd4, 4'd1);
    btn_up = 1'b0; btn_dn = 1'b0; step();

    // Write and up edge in the same cycle
    rx_rdy = 1'b1; rx_data = 8'h50; btn_up = 1'b1; step();
    rx_rdy = 1'b0; btn_up = 1'b0;
    check("write_plus_up", 8'h20, 4'd5, 4'd3);
    step();

    // Write and down edge at offset 0 shows the new byte
    press_dn(); press_dn(); press_dn();
    check("back_to_newest", 8'h50, 4'd5, 4'd0);
    rx_rdy = 1'b1; rx_data = 8'h55; btn_dn = 1'b1; step();
    rx_rdy = 1'b0; btn_dn = 1'b0;
    check("write_plus_dn_newest", 8'h55, 4'd6, 4'd0);
    step();

    // rx_rdy held high writes one byte per cycle
    press_up(); press_up();
    check("pre_burst", 8'h40, 4'd6, 4'd2);
    rx_rdy = 1'b1;
    rx_data = 8'h60; step();
    rx_data = 8'h70; step();
    rx_data = 8'h80; step();
    rx_rdy = 1'b0;
    check("burst_write", 8'h40, 4'd8, 4'd5);
    press_dn(); press_dn(); press_dn(); press_dn(); press_dn();
    check("burst_newest", 8'h80, 4'd8, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_display_buffer.md
RX_DISPLAY_BUFFER -- requirements
Module: rx_display_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of received bytes held in history; SHALL be a power of two, 2..8.
REQ-002 clk_50Mhz  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_rdy  input  1  one-cycle strobe from the UART receiver: rx_data is valid this cycle.
REQ-005 rx_data  input  8  received byte.
REQ-006 btn_up  input  1  debounced level; a rising edge browses one byte older.
REQ-007 btn_dn  input  1  debounced level; a rising edge browses one byte newer.
REQ-008 d_hi  output  4  upper nibble of the viewed byte.
REQ-009 d_lo  output  4  lower nibble of the viewed byte.
REQ-010 bytesel_hi  output  4  number of bytes stored (0..DEPTH).
REQ-011 bytesel_lo  output  4  view offset; 0 = newest byte.

Function
REQ-012 Storage SHALL be a DEPTH-entry circular buffer, with a write pointer of log2(DEPTH) bits that wraps from DEPTH-1 to 0.
REQ-013 On rx_rdy, the block SHALL write rx_data at wr_ptr, increment wr_ptr (mod DEPTH), and increment count, saturating at DEPTH.
REQ-014 When count==DEPTH, a new write SHALL overwrite the oldest entry.
REQ-015 The viewed byte SHALL be mem[(wr_ptr-1-offset) mod DEPTH]; when count==0 the viewed byte SHALL read as 8'h00.
REQ-016 Button edges SHALL be detected internally with a registered previous level; only a 0->1 transition counts as an event, so a held button produces exactly one event.
REQ-017 Up event: offset SHALL increment when offset < count-1; otherwise it is unchanged.
REQ-018 Down event: offset SHALL decrement when offset > 0; otherwise it is unchanged.
REQ-019 Up and down events in the same cycle SHALL both be ignored.
REQ-020 Write with offset > 0: offset SHALL increment so the same byte stays in view, clamped to DEPTH-1.
REQ-021 Write with offset == 0: offset SHALL stay 0, so the new byte is shown.
REQ-022 Write and button event in the same cycle: the write adjustment SHALL be applied first, then the button rule evaluated against the post-write count, then the result clamped to [0, max(count_next-1, 0)].
REQ-023 All outputs SHALL be registered; any event SHALL be reflected on outputs exactly 1 cycle after the triggering edge.
REQ-024 rx_rdy held high for N cycles SHALL write N bytes (no edge filtering on rx_rdy).

Reset
REQ-025 While reset is high, wr_ptr, count, offset, button history registers and all outputs SHALL be 0, independent of the clock.
REQ-026 Reset asserted mid-browse or mid-write SHALL discard history and the in-flight write.
REQ-027 Buffer memory contents need not be cleared, because count==0 masks them.
REQ-028 After reset deassertion, a button already held high SHALL NOT generate an event until it is released and pressed again.

Structure
REQ-029 A shared package SHALL hold DEPTH_DEFAULT, the pointer width derived from DEPTH, and the 4-bit nibble width constant.
REQ-030 One sub-module, rise_edge_detect (clk, reset, level -> pulse), SHALL be instantiated twice, once per button.
REQ-031 Outputs connect one-to-one to the display controller's bytesel_hi, bytesel_lo, d_hi and d_lo inputs.

Verification
REQ-032 Reset, then write 8'hA5 -> next cycle d_hi=A, d_lo=5, bytesel_hi=1, bytesel_lo=0.
REQ-033 Write 8'h11..8'h88 (8 bytes) then 8'h99 -> bytesel_hi=8, view=99; 7 up edges -> view=22, offset=7; 8th up edge -> unchanged.
REQ-034 With 3 bytes (10,20,30), press up twice -> view=10; write 40 -> offset=3, view still 10; press down 3 times -> view=40, offset 0; 4th down -> no change.
REQ-035 btn_up held 100 cycles -> exactly one offset increment; btn_up and btn_dn rising together -> offset unchanged.
REQ-036 Full buffer, offset=7; write 8'hEE -> offset clamps to 7, viewed byte becomes the new oldest entry.
REQ-037 Assert reset asynchronously between clock edges mid-browse -> all outputs 0 before the next edge; btn_up held through reset -> no event after release of reset.
